axis_cfg_sched: RTL
===================

Name: axis_cfg_sched

Overview:
- Round-robin scheduler that shares one cfg bus among NB_REQ descriptor requesters.
- Each accepted descriptor (engine id, address, length) is serialised into the 3-beat engine programming sequence consumed by the axis_read/axis_write engines: select beat, address beat, length beat.
- Sits between software- or DMA-side descriptor sources and the cfg bus of the AXI stream engines.
- Guarantees a sequence is never interleaved with another requester's beats.

Parameters:
- NB_REQ, 4, number of requesters (>=2).
- ID_WIDTH, 8, width of the engine id field; zero-extended onto cfg_data.
- CFG_ADDR, 23, cfg register address of the select beat.
- CFG_DATA, 24, cfg register address of the address and length beats.
- CFG_AWIDTH, 5, cfg address width.
- CFG_DWIDTH, 32, cfg data, address and length width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_id  in  NB_REQ*ID_WIDTH  per-requester target engine id; requester i at [i*ID_WIDTH +: ID_WIDTH]
- req_address  in  NB_REQ*CFG_DWIDTH  per-requester start byte address
- req_length  in  NB_REQ*CFG_DWIDTH  per-requester length in DATA_WIDTH words
- req_valid  in  NB_REQ  descriptor valid
- req_ready  out  NB_REQ  descriptor accepted (one-hot, one-cycle pulse)
- cfg_addr  out  CFG_AWIDTH  cfg bus address
- cfg_data  out  CFG_DWIDTH  cfg bus data
- cfg_valid  out  1  cfg beat valid
- cfg_ready  in  1  cfg beat accepted when high with cfg_valid
- grant  out  $clog2(NB_REQ)  index of last granted requester
- busy  out  1  sequence in progress
- issued_cnt  out  16  count of descriptors fully issued; wraps

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- Reset values: req_ready=0, cfg_valid=0, cfg_addr=0, cfg_data=0, busy=0, grant=NB_REQ-1 (so requester 0 has first priority), issued_cnt=0, state=IDLE.
- All outputs are registered.
- FSM states (one-hot): IDLE, SEL, ADDR, LEN.
- IDLE:
  - If any req_valid, pick the first asserted index scanning from grant+1 modulo NB_REQ.
  - Pulse req_ready[k] for one cycle, latch id/address/length of k into the descriptor register, and set grant=k.
  - Next state is SEL, or stay IDLE if the latched length==0.
  - A zero-length descriptor is consumed (req_ready pulses, grant updates) but emits no cfg beats and does not increment issued_cnt.
- Requester protocol: the descriptor must be held stable while req_valid is high. Transfer occurs on req_valid&req_ready, so the grant cycle is the transfer.
- SEL: cfg_addr=CFG_ADDR, cfg_data={zeros,id}, cfg_valid=1. Held until cfg_ready, then go to ADDR.
- ADDR: cfg_addr=CFG_DATA, cfg_data=address, cfg_valid=1. Held until cfg_ready, then go to LEN.
- LEN: cfg_addr=CFG_DATA, cfg_data=length, cfg_valid=1.
  - On cfg_ready: cfg_valid drops next cycle, issued_cnt+1, return to IDLE.
- Bus rules:
  - cfg_valid, once high, stays high with stable addr/data until cfg_ready.
  - cfg_ready low stalls the FSM indefinitely (engine in STALL). No timeout.
  - No cfg beat from another requester is emitted between SEL and LEN.
- busy=1 from the cycle after grant until the LEN beat is accepted.
- Minimum descriptor spacing is 4 cycles with cfg_ready tied high: grant, SEL, ADDR, LEN. The next grant can occur in the cycle after the LEN transfer.
- Round-robin fairness: with all requesters valid, grants cycle 0,1,2,3,0,...
- Requests arriving during busy wait. No descriptor is lost or duplicated.
- Reset mid-sequence:
  - The FSM returns to IDLE with cfg_valid=0 the next cycle and the partial sequence is abandoned.
  - Engines share rst, so they also return to their idle state.
- issued_cnt wraps 0xFFFF -> 0.

Decomposition:
- Shared package: localparams for the cfg register addresses CFG_ADDR/CFG_DATA, the beat count (3), and the state encoding indices.
- One sub-module: axis_cfg_rr_arb (NB_REQ-wide round-robin priority picker).
  - Inputs: req vector, last-grant index.
  - Outputs: one-hot grant and encoded index; combinational.
- The FSM and descriptor register stay in the top.

Test Plan:
- Single descriptor: req 0, id=1, addr=0x1000_0000, len=64, cfg_ready=1 -> beats (23,1), (24,0x10000000), (24,64) on 3 consecutive cycles; issued_cnt=1; busy low after.
- Backpressure: same descriptor, cfg_ready low 5 cycles during the ADDR beat -> cfg_addr/cfg_data/cfg_valid stable for all stalled cycles; LEN beat follows only after acceptance.
- Fairness: all 4 requesters valid continuously for 8 descriptors -> grant order 0,1,2,3,0,1,2,3; each sequence contiguous; issued_cnt=8.
- Zero length: req 2 len=0, then req 3 len=16 -> req_ready[2] pulses with no cfg beats; req 3 sequence issued; issued_cnt=1.
- Reset mid-sequence: assert rst during the ADDR beat -> next cycle cfg_valid=0, busy=0, grant=NB_REQ-1; a subsequent request restarts at the SEL beat.
- Counter wrap: preload via 65536 zero-stall descriptors (or force) -> issued_cnt goes 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/axis_cfg_sched_pkg.sv
// rtl/axis_cfg_sched_pkg.sv - shared constants and state encoding for the cfg bus scheduler
package axis_cfg_sched_pkg;

  localparam int CFG_SEL_REG  = 23;
  localparam int CFG_DATA_REG = 24;
  localparam int BEAT_CNT     = 3;

  localparam int ST_NUM      = 4;
  localparam int ST_IDLE_BIT = 0;
  localparam int ST_SEL_BIT  = 1;
  localparam int ST_ADDR_BIT = 2;
  localparam int ST_LEN_BIT  = 3;

  typedef enum logic [ST_NUM-1:0] {
    ST_IDLE = ST_NUM'(1 << ST_IDLE_BIT),
    ST_SEL  = ST_NUM'(1 << ST_SEL_BIT),
    ST_ADDR = ST_NUM'(1 << ST_ADDR_BIT),
    ST_LEN  = ST_NUM'(1 << ST_LEN_BIT)
  } state_t;

endpackage

// File: rtl/axis_cfg_rr_arb.sv
// rtl/axis_cfg_rr_arb.sv - combinational round-robin picker scanning from last+1
module axis_cfg_rr_arb #(
  parameter int NB_REQ = 4,
  parameter int IDX_W  = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NB_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    // last itself is visited last, so a lone requester can be re-granted
    for (int i = 1; i <= NB_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NB_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any      = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/axis_cfg_sched.sv
// rtl/axis_cfg_sched.sv - round-robin serialiser of descriptors into 3-beat cfg programming sequences
module axis_cfg_sched
  import axis_cfg_sched_pkg::*;
#(
  parameter int NB_REQ     = 4,
  parameter int ID_WIDTH   = 8,
  parameter int CFG_ADDR   = CFG_SEL_REG,
  parameter int CFG_DATA   = CFG_DATA_REG,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NB_REQ*ID_WIDTH-1:0]   req_id,
  input  logic [NB_REQ*CFG_DWIDTH-1:0] req_address,
  input  logic [NB_REQ*CFG_DWIDTH-1:0] req_length,
  input  logic [NB_REQ-1:0]            req_valid,
  output logic [NB_REQ-1:0]            req_ready,
  output logic [CFG_AWIDTH-1:0]        cfg_addr,
  output logic [CFG_DWIDTH-1:0]        cfg_data,
  output logic                         cfg_valid,
  input  logic                         cfg_ready,
  output logic [$clog2(NB_REQ)-1:0]    grant,
  output logic                         busy,
  output logic [15:0]                  issued_cnt
);

  localparam int GW = $clog2(NB_REQ);

  state_t                state_q, state_d;
  logic [NB_REQ-1:0]     req_ready_d;
  logic [CFG_AWIDTH-1:0] cfg_addr_d;
  logic [CFG_DWIDTH-1:0] cfg_data_d;
  logic                  cfg_valid_d;
  logic [GW-1:0]         grant_d;
  logic                  busy_d;
  logic [15:0]           issued_d;

  logic [ID_WIDTH-1:0]   desc_id, desc_id_d;
  logic [CFG_DWIDTH-1:0] desc_addr, desc_addr_d;
  logic [CFG_DWIDTH-1:0] desc_len, desc_len_d;

  logic [NB_REQ-1:0]     arb_oh;
  logic [GW-1:0]         arb_idx;
  logic                  arb_any;
  logic                  take;

  axis_cfg_rr_arb #(
    .NB_REQ (NB_REQ),
    .IDX_W  (GW)
  ) u_arb (
    .req     (req_valid),
    .last    (grant),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_ready  <= '0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      cfg_valid  <= 1'b0;
      grant      <= GW'(NB_REQ - 1);
      busy       <= 1'b0;
      issued_cnt <= '0;
      desc_id    <= '0;
      desc_addr  <= '0;
      desc_len   <= '0;
    end else begin
      state_q    <= state_d;
      req_ready  <= req_ready_d;
      cfg_addr   <= cfg_addr_d;
      cfg_data   <= cfg_data_d;
      cfg_valid  <= cfg_valid_d;
      grant      <= grant_d;
      busy       <= busy_d;
      issued_cnt <= issued_d;
      desc_id    <= desc_id_d;
      desc_addr  <= desc_addr_d;
      desc_len   <= desc_len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    cfg_addr_d  = cfg_addr;
    cfg_data_d  = cfg_data;
    cfg_valid_d = cfg_valid;
    grant_d     = grant;
    busy_d      = busy;
    issued_d    = issued_cnt;
    desc_id_d   = desc_id;
    desc_addr_d = desc_addr;
    desc_len_d  = desc_len;
    take        = 1'b0;

    unique case (state_q)
      // IDLE with req_ready high is the grant cycle; req inputs still show the old descriptor
      ST_IDLE: begin
        if (|req_ready) begin
          if (desc_len != '0) begin
            state_d     = ST_SEL;
            cfg_valid_d = 1'b1;
            busy_d      = 1'b1;
            cfg_addr_d  = CFG_AWIDTH'(CFG_ADDR);
            cfg_data_d  = CFG_DWIDTH'(desc_id);
          end
        end else begin
          take = arb_any;
        end
      end
      ST_SEL: begin
        if (cfg_ready) begin
          state_d    = ST_ADDR;
          cfg_addr_d = CFG_AWIDTH'(CFG_DATA);
          cfg_data_d = desc_addr;
        end
      end
      ST_ADDR: begin
        if (cfg_ready) begin
          state_d    = ST_LEN;
          cfg_data_d = desc_len;
        end
      end
      ST_LEN: begin
        if (cfg_ready) begin
          state_d     = ST_IDLE;
          cfg_valid_d = 1'b0;
          busy_d      = 1'b0;
          issued_d    = issued_cnt + 16'd1;
          take        = arb_any;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cfg_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

    if (take) begin
      req_ready_d = arb_oh;
      grant_d     = arb_idx;
      desc_id_d   = req_id[int'(arb_idx)*ID_WIDTH +: ID_WIDTH];
      desc_addr_d = req_address[int'(arb_idx)*CFG_DWIDTH +: CFG_DWIDTH];
      desc_len_d  = req_length[int'(arb_idx)*CFG_DWIDTH +: CFG_DWIDTH];
    end
  end

endmodule
